// File: rtl/ervp_loop_address_generator.sv
// ervp_loop_address_generator
// Two-level nested-loop address sequencer. Each launched job emits
// base + i1*stride1 + i0*stride0 for every (i1, i0) point, inner loop first,
// over a valid/ready handshake, flags the first/last address and pulses done.
// Optional feature macro: ERVP_LOOP_ADDRGEN_ABORT_EN adds an abort input that
// ends a running job early.
module ervp_loop_address_generator #(
  parameter int BW_ADDR   = 32,
  parameter int BW_COUNT  = 16,
  parameter int BW_STRIDE = 16
) (
  input  logic                 clk,
  input  logic                 rstp,
  input  logic                 enable,
  input  logic                 start,
`ifdef ERVP_LOOP_ADDRGEN_ABORT_EN
  input  logic                 abort,
`endif
  input  logic [BW_ADDR-1:0]   base_addr,
  input  logic [BW_COUNT-1:0]  count0,
  input  logic [BW_COUNT-1:0]  count1,
  input  logic [BW_STRIDE-1:0] stride0,
  input  logic [BW_STRIDE-1:0] stride1,
  output logic                 busy,
  output logic                 done,
  output logic                 addr_valid,
  input  logic                 addr_ready,
  output logic [BW_ADDR-1:0]   addr,
  output logic                 addr_first,
  output logic                 addr_last
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e               state_q, state_d;
  logic [BW_COUNT-1:0]  count0_q, count0_d;
  logic [BW_COUNT-1:0]  count1_q, count1_d;
  logic [BW_STRIDE-1:0] stride0_q, stride0_d;
  logic [BW_STRIDE-1:0] stride1_q, stride1_d;
  logic [BW_COUNT-1:0]  i0_q, i0_d;
  logic [BW_COUNT-1:0]  i1_q, i1_d;
  logic [BW_ADDR-1:0]   row_addr_q, row_addr_d;
  logic [BW_ADDR-1:0]   addr_q, addr_d;

  logic [BW_ADDR-1:0]   stride0_ext;
  logic [BW_ADDR-1:0]   stride1_ext;
  logic                 i0_end;
  logic                 i1_end;
  logic                 running;
  logic                 xfer;
  logic                 abort_req;

`ifdef ERVP_LOOP_ADDRGEN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Strides are signed; widening them lets plain addition wrap modulo 2^BW_ADDR.
  assign stride0_ext = BW_ADDR'(signed'(stride0_q));
  assign stride1_ext = BW_ADDR'(signed'(stride1_q));

  assign i0_end  = (i0_q == count0_q - BW_COUNT'(1));
  assign i1_end  = (i1_q == count1_q - BW_COUNT'(1));
  assign running = (state_q == ST_RUN);
  assign xfer    = running & addr_ready & enable;

  // Outputs come straight from registered state; enable only gates valid/done.
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE) & enable;
  assign addr_valid = running & enable;
  assign addr       = addr_q;
  assign addr_first = running & (i0_q == '0) & (i1_q == '0);
  assign addr_last  = running & i0_end & i1_end;

  // Next-state and loop-index update logic.
  always_comb begin
    // NOTE: every _d starts from its _q so untaken branches hold state and no latch is inferred.
    state_d    = state_q;
    count0_d   = count0_q;
    count1_d   = count1_q;
    stride0_d  = stride0_q;
    stride1_d  = stride1_q;
    i0_d       = i0_q;
    i1_d       = i1_q;
    row_addr_d = row_addr_q;
    addr_d     = addr_q;

    case (state_q)
      ST_IDLE: begin
        if (start && enable) begin
          count0_d   = count0;
          count1_d   = count1;
          stride0_d  = stride0;
          stride1_d  = stride1;
          i0_d       = '0;
          i1_d       = '0;
          row_addr_d = base_addr;
          addr_d     = base_addr;
          state_d    = (count0 == '0 || count1 == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          if (!i0_end) begin
            i0_d   = i0_q + BW_COUNT'(1);
            addr_d = addr_q + stride0_ext;
          end else if (!i1_end) begin
            i0_d       = '0;
            i1_d       = i1_q + BW_COUNT'(1);
            row_addr_d = row_addr_q + stride1_ext;
            addr_d     = row_addr_q + stride1_ext;
          end else begin
            state_d = ST_DONE;
          end
        end
        // Abort overrides the loop but lets a same-cycle transfer complete.
        if (enable && abort_req) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (enable) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      state_q    <= ST_IDLE;
      count0_q   <= '0;
      count1_q   <= '0;
      stride0_q  <= '0;
      stride1_q  <= '0;
      i0_q       <= '0;
      i1_q       <= '0;
      row_addr_q <= '0;
      addr_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      count0_q   <= count0_d;
      count1_q   <= count1_d;
      stride0_q  <= stride0_d;
      stride1_q  <= stride1_d;
      i0_q       <= i0_d;
      i1_q       <= i1_d;
      row_addr_q <= row_addr_d;
      addr_q     <= addr_d;
    end
  end

endmodule

// File: doc/ervp_loop_address_generator.md
# ervp_loop_address_generator

Two-level nested-loop address sequencer that drives a downstream address stream through a valid/ready handshake. It sits directly upstream of the reconfigurable counter and memory-access stages: per launched job it emits base + i1*stride1 + i0*stride0 for every (i1, i0) point, with inner-loop-first ordering. It flags the first and last address of each job and signals job completion.

## Interface
- BW_ADDR, 32, address width; all address arithmetic is modulo 2^BW_ADDR.
- BW_COUNT, 16, width of the iteration-count inputs.
- BW_STRIDE, 16, width of the signed stride inputs.

Ports:
- clk  input  1  sole clock, rising edge.
- rstp  input  1  reset; asynchronous, active-high.
- enable  input  1  global advance enable; low freezes all state.
- start  input  1  launch a job; sampled only in IDLE.
- base_addr  input  BW_ADDR  start address.
- count0  input  BW_COUNT  inner-loop iteration count.
- count1  input  BW_COUNT  outer-loop iteration count.
- stride0  input  BW_STRIDE  signed inner stride.
- stride1  input  BW_STRIDE  signed outer stride.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse at job end.
- addr_valid  output  1  addr holds a valid address.
- addr_ready  input  1  consumer accepts addr.
- addr  output  BW_ADDR  current address.
- addr_first  output  1  current address is the job's first (i0=i1=0).
- addr_last  output  1  current address is the job's last.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE + start + enable:
  - latch base_addr, count0/1, stride0/1; clear i0 and i1.
  - load row_addr and addr with base_addr.
  - if count0==0 or count1==0, go to DONE; otherwise go to RUN.
- RUN:
  - addr_valid=1.
  - A transfer is addr_valid & addr_ready & enable.
  - On a transfer, if i0 < count0-1: i0++, addr += sext(stride0).
  - Else, if i1 < count1-1: i0=0, i1++, row_addr += sext(stride1), addr = row_addr + sext(stride1).
  - Else (last transfer): go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy = (state != IDLE).
- start outside IDLE is ignored. Inputs are not sampled after launch, so changing them mid-job has no effect.
- addr_first = RUN & i0==0 & i1==0.
- addr_last = RUN & i0==count0-1 & i1==count1-1.
- Without a transfer, addr and the flags are held stable while addr_valid is high.
- Strides are sign-extended to BW_ADDR. Additions wrap silently; no overflow flag.
- enable=0: FSM, indices and addresses hold, and addr_valid is forced 0, so no transfer is possible. done is also masked to 0 and re-asserts once enable returns.
- Reset values: state=IDLE, busy=0, done=0, addr_valid=0, addr=0, addr_first=0, addr_last=0, internal indices 0.

## Timing
- Launch: start sampled at edge N. addr_valid=1 with addr=base_addr from cycle N+1.
- Zero-count job: done pulses in cycle N+1; no address is emitted.
- Throughput: one address per cycle while addr_ready=1 and enable=1.
- The transfer of the last address in cycle M is followed by done=1 and addr_valid=0 in cycle M+1. The block is back in IDLE at M+2, and start is accepted in that cycle.
- Job length in cycles = count0*count1 transfers + 1 DONE cycle (back-to-back ready).
- Reset asserted mid-job immediately returns all outputs to their reset values. No done pulse is produced for the aborted job.

## Configuration
- ERVP_LOOP_ADDRGEN_ABORT_EN defined: adds input abort (1 bit).
  - abort=1 with enable=1 in RUN forces DONE on the next edge, whether or not a transfer occurs that cycle. done pulses normally.
  - Any transfer in that same cycle still completes.
  - abort in IDLE or DONE has no effect.
- Not defined: no abort port. A job ends only after its last transfer or on reset.

## Test plan
- Basic 2D: base=0x1000, count0=3, count1=2, stride0=4, stride1=0x100, ready held 1 -> addresses 0x1000,0x1004,0x1008,0x1100,0x1104,0x1108 on consecutive cycles. addr_first on the first address only, addr_last on 0x1108 only. done one cycle later.
- Backpressure: same job, addr_ready toggled 1,0,0,1... -> addr and flags held stable during ready=0 cycles. Sequence unchanged, no duplicates or skips.
- Negative stride/wrap: base=0x00000004, count0=3, count1=1, stride0=-4 -> 0x4, 0x0, 0xFFFFFFFC.
- Zero count: count0=0, count1=5, start -> done pulse next cycle, addr_valid never asserts. A new start issued 1 cycle after done is accepted.
- Enable/reset: deassert enable for 3 cycles mid-job -> addr_valid=0 and state held, sequence resumes where it stopped. Assert rstp mid-job -> busy, addr_valid and done drop to 0 immediately, with no done pulse.
- ABORT_EN build: abort asserted on the 2nd address of a 6-address job with ready=1 -> exactly 2 transfers, then done. Non-ABORT build: port is absent.
